// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-back write-allocate cache controller
//
// Sits between a CPU load/store port and main memory. Drives an external tag
// array and data array through a shared index. All valid bits are cleared after
// reset (INIT), then one FSM services hits, dirty evictions and refills.
//
// Optional feature macro: CACHE_STATS_EN (adds hit_count / miss_count outputs).
//
// Ports:
//   iCLK, iRST_N                 clock (rising edge), async active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request, held until cpu_ready
//   cpu_rdata/cpu_ready          load data and one-cycle completion pulse
//   idx                          index into tag and data arrays
//   tag_we/tag_block_in          tag array write port {valid, dirty, tag}
//   tag_block_out                tag block at idx (combinational read)
//   data_we/data_wdata           data array write port
//   data_rdata                   data word at idx (combinational read)
//   mem_req/mem_we/mem_addr/mem_wdata   main-memory request, held until mem_ack
//   mem_rdata/mem_ack            refill data and one-cycle completion
//   hit_count/miss_count         access statistics (CACHE_STATS_EN only)

module cache_controller #(
    parameter int ADDR_W    = 32,
    parameter int OFFSET_W  = 2,
    parameter int IDX_W     = 5,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = ADDR_W - IDX_W - OFFSET_W,
    parameter int TAG_MEM_W = TAG_W + 2
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_ready,
    output logic [IDX_W-1:0]     idx,
    output logic                 tag_we,
    output logic [TAG_MEM_W-1:0] tag_block_in,
    input  logic [TAG_MEM_W-1:0] tag_block_out,
    output logic                 data_we,
    output logic [DATA_W-1:0]    data_wdata,
    input  logic [DATA_W-1:0]    data_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count
`endif
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;

    // Byte-offset bits never reach the arrays or memory.
    logic unused_offset;
    assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             blk_valid;
    logic             blk_dirty;
    logic [TAG_W-1:0] blk_tag;
    logic             hit;

    assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx   = addr_q[OFFSET_W +: IDX_W];
    assign blk_valid = tag_block_out[TAG_MEM_W-1];
    assign blk_dirty = tag_block_out[TAG_MEM_W-2];
    assign blk_tag   = tag_block_out[TAG_W-1:0];
    assign hit       = blk_valid && (blk_tag == req_tag);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_INIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == S_IDLE && cpu_req) begin
                addr_q  <= cpu_addr;
                we_q    <= cpu_we;
                wdata_q <= cpu_wdata;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cpu_rdata    = '0;
        cpu_ready    = 1'b0;
        idx          = req_idx;
        tag_we       = 1'b0;
        tag_block_in = '0;
        data_we      = 1'b0;
        data_wdata   = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (state_q)
            S_INIT: begin
                idx    = cnt_q;
                tag_we = 1'b1;
                if (&cnt_q) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cpu_req) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    if (we_q) begin
                        data_we      = 1'b1;
                        data_wdata   = wdata_q;
                        tag_we       = 1'b1;
                        tag_block_in = {2'b11, req_tag};
                    end else begin
                        cpu_rdata = data_rdata;
                    end
                    state_d = S_IDLE;
                end else if (blk_valid && blk_dirty) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                // Arrays are untouched here, so the old tag and word stay stable.
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {blk_tag, req_idx, {OFFSET_W{1'b0}}};
                mem_wdata = data_rdata;
                if (mem_ack) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, {OFFSET_W{1'b0}}};
                if (mem_ack) begin
                    data_we      = 1'b1;
                    data_wdata   = mem_rdata;
                    tag_we       = 1'b1;
                    tag_block_in = {2'b10, req_tag};
                    state_d      = S_COMPARE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    // Set on acceptance, cleared on the first COMPARE so the re-compare after
    // a refill is not counted a second time.
    logic first_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            first_q    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state_q == S_IDLE && cpu_req) begin
                first_q <= 1'b1;
            end else if (state_q == S_COMPARE) begin
                first_q <= 1'b0;
                if (first_q) begin
                    if (hit) begin
                        hit_count <= hit_count + 32'd1;
                    end else begin
                        miss_count <= miss_count + 32'd1;
                    end
                end
            end
        end
    end
`endif

endmodule
